pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error (1..255, 8-bit counter).
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 id_rs1_addr, id_rs2_addr  in  5 each  source regs of instruction in decode.
REQ-005 ex_rs1_addr, ex_rs2_addr  in  5 each  source regs of instruction in execute.
REQ-006 ex_rd_addr  in  5;  ex_reg_wr_en  in  1;  ex_mem_read  in  1  execute-stage dest and load flag.
REQ-007 mem_rd_addr  in  5;  mem_reg_wr_en  in  1;  mem_access  in  1  memory-stage dest and data-memory access flag (load or store).
REQ-008 wb_rd_addr  in  5;  wb_reg_wr_en  in  1  writeback-stage dest.
REQ-009 branch_taken  in  1  redirect resolved in execute (branch taken or jump).
REQ-010 dmem_ack  in  1  data memory completes current access this cycle.
REQ-011 pc_wr_en, pc_sel  out  1 each  PC update enable; 1 selects redirect target.
REQ-012 if_wr_en, if_clear, id_wr_en, id_clear, ex_wr_en, ex_clear, wb_wr_en, wb_clear  out  1 each  stage register controls; clear overrides wr_en.
REQ-013 fwd_op1_sel, fwd_op2_sel  out  2 each  00 register file, 01 memory-stage ALU result, 10 writeback data.
REQ-014 mem_err  out  1  sticky timeout flag.

Function
REQ-015 FSM states RUN, MEM_WAIT, ERROR; outputs are combinational from state and inputs.
REQ-016 RUN default: all wr_en=1, all clear=0, pc_wr_en=1, pc_sel=0.
REQ-017 Freeze: in RUN with mem_access=1 and dmem_ack=0 -> pc/if/id/ex wr_en=0, wb_clear=1, go MEM_WAIT, counter loads 1.
REQ-018 MEM_WAIT: same freeze outputs; counter increments each cycle; dmem_ack=1 -> RUN-default outputs that cycle, return RUN, counter clears.
REQ-019 MEM_WAIT with counter==MEM_TIMEOUT and dmem_ack=0 -> go ERROR.
REQ-020 ERROR: all wr_en=0, pc_wr_en=0, mem_err=1; exits only on rst.
REQ-021 Flush: branch_taken=1, not frozen -> pc_sel=1, if_clear=1, id_clear=1, pc_wr_en=1.
REQ-022 Load-use: ex_mem_read=1, ex_reg_wr_en=1, ex_rd_addr!=0, ex_rd_addr equals id_rs1_addr or id_rs2_addr, not frozen, no flush -> pc_wr_en=0, if_wr_en=0, id_clear=1; exactly one bubble.
REQ-023 Priority: freeze > flush > load-use stall; branch_taken during freeze is held and acted on in the first unfrozen cycle.
REQ-024 Forwarding per operand: mem_reg_wr_en && mem_rd_addr!=0 && match -> 01; else wb_reg_wr_en && wb_rd_addr!=0 && match -> 10; else 00.
REQ-025 Forwarding is independent of FSM state; x0 is never forwarded.
REQ-026 dmem_ack with mem_access=0 in RUN is ignored.

Reset
REQ-027 rst=1 at a clock edge: state=RUN, counter=0, mem_err=0, perf counters=0.
REQ-028 While rst=1: all wr_en=0, pc_wr_en=0, all clear=1, pc_sel=0, fwd sels=00.
REQ-029 Reset mid-MEM_WAIT or in ERROR returns to RUN on the next edge.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN: when defined, adds out stall_cycles[31:0] and flush_count[31:0].
REQ-031 stall_cycles increments on every freeze or load-use cycle; flush_count increments on every flush cycle; both wrap at 2^32.
REQ-032 Without PIPE_CTRL_PERF_EN: ports absent, no counter logic, all other behaviour identical.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> exactly one cycle pc_wr_en=0, if_wr_en=0, id_clear=1, then RUN.
REQ-034 Flush: branch_taken=1 in RUN -> pc_sel=1, if_clear=1, id_clear=1 for that cycle only.
REQ-035 Wait: mem_access=1, dmem_ack low for 3 cycles -> 3 frozen cycles with wb_clear=1, resume on the ack cycle; stall_cycles=3 when enabled.
REQ-036 Timeout: MEM_TIMEOUT=4, dmem_ack never -> ERROR after 4 wait cycles, mem_err=1 until rst; rst -> RUN.
REQ-037 Forwarding: mem_rd=3, wb_rd=3 both write, ex_rs1=3 -> fwd_op1_sel=01; mem_rd=0 only -> 00.
REQ-038 Priority: branch_taken and load-use hazard during a freeze -> only freeze outputs; after dmem_ack, flush outputs and no stall.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Purpose:
//   Generates PC and stage-register write-enable/clear controls, operand
//   forwarding selects, and a sticky data-memory timeout flag. A three-state
//   FSM (RUN / MEM_WAIT / ERROR) freezes the pipeline while the data memory
//   is busy and traps into ERROR when an access exceeds MEM_TIMEOUT wait
//   cycles. Priority: memory freeze > branch flush > load-use stall.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before error (1..255)
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_rs1_addr, id_rs2_addr         decode-stage source registers
//   ex_rs1_addr, ex_rs2_addr         execute-stage source registers
//   ex_rd_addr, ex_reg_wr_en,
//   ex_mem_read                      execute-stage destination / load flag
//   mem_rd_addr, mem_reg_wr_en,
//   mem_access                       memory-stage destination / dmem access
//   wb_rd_addr, wb_reg_wr_en         writeback-stage destination
//   branch_taken                     redirect resolved in execute
//   dmem_ack                         data memory completes access this cycle
//   pc_wr_en, pc_sel                 PC enable, redirect-target select
//   *_wr_en, *_clear                 stage register controls (clear wins)
//   fwd_op1_sel, fwd_op2_sel         00 regfile, 01 mem-stage, 10 wb-stage
//   mem_err                          sticky timeout flag (cleared by rst)
//
// Optional build macro PIPE_CTRL_PERF_EN adds:
//   stall_cycles[31:0]               freeze + load-use stall cycle count
//   flush_count[31:0]                flush cycle count

module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  ex_rs1_addr,
    input  logic [4:0]  ex_rs2_addr,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_wr_en,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_wr_en,
    input  logic        mem_access,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_wr_en,
    input  logic        branch_taken,
    input  logic        dmem_ack,
    output logic        pc_wr_en,
    output logic        pc_sel,
    output logic        if_wr_en,
    output logic        if_clear,
    output logic        id_wr_en,
    output logic        id_clear,
    output logic        ex_wr_en,
    output logic        ex_clear,
    output logic        wb_wr_en,
    output logic        wb_clear,
    output logic [1:0]  fwd_op1_sel,
    output logic [1:0]  fwd_op2_sel,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        branch_hold;   // redirect seen while frozen, replayed later
    logic        frozen;
    logic        flush;
    logic        load_use;

    // Hazard classification (combinational, shared by FSM and outputs)
    always_comb begin
        frozen   = ((state == RUN) && mem_access && !dmem_ack) ||
                   ((state == MEM_WAIT) && !dmem_ack);
        flush    = (state != ERROR) && !frozen &&
                   (branch_taken || branch_hold);
        load_use = (state != ERROR) && !frozen && !flush &&
                   ex_mem_read && ex_reg_wr_en && (ex_rd_addr != 5'd0) &&
                   ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            branch_hold <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            // Accumulate redirects across the whole freeze; drop once acted on
            branch_hold <= frozen ? (branch_hold | branch_taken) : 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_access && !dmem_ack) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_nxt    = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = RUN;
        endcase
    end

    // Forwarding select: memory stage has priority over writeback, x0 never
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_reg_wr_en && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs))
            return 2'b01;
        else if (wb_reg_wr_en && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Output logic
    always_comb begin
        pc_wr_en    = 1'b1;
        pc_sel      = 1'b0;
        if_wr_en    = 1'b1;
        if_clear    = 1'b0;
        id_wr_en    = 1'b1;
        id_clear    = 1'b0;
        ex_wr_en    = 1'b1;
        ex_clear    = 1'b0;
        wb_wr_en    = 1'b1;
        wb_clear    = 1'b0;
        fwd_op1_sel = fwd_sel(ex_rs1_addr);
        fwd_op2_sel = fwd_sel(ex_rs2_addr);
        mem_err     = (state == ERROR);

        if (rst) begin
            pc_wr_en    = 1'b0;
            if_wr_en    = 1'b0;
            id_wr_en    = 1'b0;
            ex_wr_en    = 1'b0;
            wb_wr_en    = 1'b0;
            if_clear    = 1'b1;
            id_clear    = 1'b1;
            ex_clear    = 1'b1;
            wb_clear    = 1'b1;
            fwd_op1_sel = 2'b00;
            fwd_op2_sel = 2'b00;
        end else if (state == ERROR) begin
            pc_wr_en = 1'b0;
            if_wr_en = 1'b0;
            id_wr_en = 1'b0;
            ex_wr_en = 1'b0;
            wb_wr_en = 1'b0;
        end else if (frozen) begin
            pc_wr_en = 1'b0;
            if_wr_en = 1'b0;
            id_wr_en = 1'b0;
            ex_wr_en = 1'b0;
            wb_clear = 1'b1;
        end else if (flush) begin
            pc_sel   = 1'b1;
            if_clear = 1'b1;
            id_clear = 1'b1;
        end else if (load_use) begin
            pc_wr_en = 1'b0;
            if_wr_en = 1'b0;
            id_clear = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (frozen || load_use)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
